cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Multicycle sequencer for the single-issue Minisys CPU; sits between control32 decode outputs and the datapath enables (PC, IR, register file, data memory/IO).
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Waits on ready handshakes from instruction and data memory, and traps to a sticky FAULT on data-memory timeout.
- Provides a pause request and an instruction-retired counter.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles MEM waits for dmem_ready before FAULT (1..255).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Jr, Jmp, Jal, Branch, nBranch, MemWrite, MemtoReg, RegWrite  in  1 each  decode signals from control32, stable from DECODE through end of instruction.
- zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data memory/IO access complete this cycle.
- halt  in  1  pause request.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load instruction register.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write (sw); only with dmem_req.
- reg_we  out  1  register file write.
- pc_we  out  1  PC update.
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = register (jr).
- retire  out  1  one-cycle pulse per completed instruction.
- fault  out  1  sticky timeout indication.
- state  out  3  current state, for debug.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n low, async):
  - state = INIT (0), timeout count = 0, instr_count = 0.
  - All outputs 0.
- State encoding: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PAUSE=6, FAULT=7. Outputs are combinational from state plus listed inputs.
- "Next FETCH" below means: go to PAUSE if halt=1 in that cycle, else FETCH.
- INIT: always go to FETCH (or PAUSE if halt=1) next cycle.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_we=1 and go to DECODE.
  - Otherwise stay in FETCH with no limit.
- DECODE:
  - Jr: pc_we=1, pc_sel=3, retire, next FETCH.
  - Jmp or Jal: pc_we=1, pc_sel=2, retire, next FETCH. Jal also sets reg_we=1 ($31 write).
  - If Jr and Jmp are both set, Jr wins.
  - Otherwise go to EXEC.
- EXEC:
  - Branch or nBranch: taken = (Branch & zero) | (nBranch & ~zero). pc_we=1, pc_sel = taken ? 1 : 0, retire, next FETCH.
  - Else MemWrite or MemtoReg: go to MEM.
  - Else RegWrite: go to WB.
  - Else (nop): pc_we=1, pc_sel=0, retire, next FETCH.
- MEM:
  - dmem_req=1, dmem_we=MemWrite. The timeout counter increments each cycle without dmem_ready.
  - dmem_ready=1: counter cleared; MemtoReg goes to WB; sw gives pc_we=1, pc_sel=0, retire, next FETCH.
  - Counter == MEM_TIMEOUT and dmem_ready=0: go to FAULT.
  - dmem_ready=1 in the same cycle as the limit: ready wins, no fault.
- WB: reg_we=1, pc_we=1, pc_sel=0, retire, next FETCH.
- PAUSE:
  - All enables 0. Return to FETCH on the first cycle halt=0.
  - halt never interrupts an instruction mid-flight; it is sampled only at instruction boundaries and in INIT.
- FAULT:
  - fault=1, all enables 0.
  - Exit only by reset; halt is ignored.
- instr_count: increments by 1 on each retire and wraps modulo 2^CNT_W.
- At most one of pc_we and ir_we is high per cycle; dmem_req is high only in MEM.
- Reset asserted mid-instruction aborts immediately. No pending writes survive; outputs drop in the same cycle.

Decomposition:
- Package cpu_seq_pkg: state encodings (3-bit constants) and PC_SEQ/PC_BR/PC_JMP/PC_JR pc_sel constants.
- One sub-module, seq_timeout_cnt: 8-bit counter with clear, enable and limit-compare output, instantiated for the MEM wait.

Test Plan:
- Reset release, imem_ready=1 on the second FETCH cycle, add (RegWrite=1) → state sequence 0,1,1,2,3,5,1. ir_we pulse in the second FETCH cycle. reg_we & pc_we & pc_sel=0 in WB. instr_count=1.
- beq with zero=1 then bne with zero=1 → first gives pc_sel=1 pc_we=1 in EXEC; second gives pc_sel=0. Both retire; instr_count=2; no reg_we.
- lw with dmem_ready after 3 wait cycles → MEM held 4 cycles with dmem_req=1 dmem_we=0, then WB reg_we=1. sw → dmem_we=1, retires from MEM without WB.
- jal → DECODE-cycle reg_we=1 pc_we=1 pc_sel=2. jr (Jr=1) → pc_sel=3 reg_we=0. Both go straight to FETCH.
- MEM_TIMEOUT=15, dmem_ready never asserted → FAULT entered after 15 MEM cycles, fault=1 sticky. Repeat with ready on exactly the limit cycle → no fault.
- halt raised during EXEC of add → instruction completes through WB, then PAUSE. Release halt → FETCH next cycle. Reset pulse in MEM → state 0, all outputs 0, instr_count 0 asynchronously.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the Minisys multicycle sequencer: FSM state codes and
// PC source selects driven onto the datapath mux.
package cpu_seq_pkg;
    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_PAUSE  = 3'd6;
    localparam logic [2:0] S_FAULT  = 3'd7;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;
endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> control32/datapath bundle. master = sequencer, slave = the
// decode/datapath side that drives decode flags and memory handshakes.
interface cpu_sequencer_if #(parameter int CNT_W = 32);
    logic Jr, Jmp, Jal, Branch, nBranch, MemWrite, MemtoReg, RegWrite;
    logic zero, imem_ready, dmem_ready, halt;
    logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we;
    logic [1:0] pc_sel;
    logic retire, fault;
    logic [2:0] state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  Jr, Jmp, Jal, Branch, nBranch, MemWrite, MemtoReg, RegWrite,
        input  zero, imem_ready, dmem_ready, halt,
        output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel,
        output retire, fault, state, instr_count
    );

    modport slave (
        output Jr, Jmp, Jal, Branch, nBranch, MemWrite, MemtoReg, RegWrite,
        output zero, imem_ready, dmem_ready, halt,
        input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel,
        input  retire, fault, state, instr_count
    );
endinterface

// File: rtl/cpu_sequencer_timeout.sv
// 8-bit wait counter for data-memory accesses. lim_o flags that the current
// enabled cycle is the LIMIT-th consecutive wait.
module seq_timeout_cnt #(
    parameter logic [7:0] LIMIT = 8'd15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic lim_o
);
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = 8'd0;
        else if (en_i) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    // Compare the post-increment value so the trap lands after exactly LIMIT waits.
    assign lim_o = en_i && (cnt_d == LIMIT);
endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with pause, sticky data-memory
// timeout trap and retired-instruction counter. Outputs are Mealy from state.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic             clock,
    input logic             rst_n,
    cpu_sequencer_if.master bus
);
    logic [2:0]       state_q, state_d, next_fetch;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_mem, to_lim, taken;
    logic             imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire, fault;
    logic [1:0]       pc_sel;

    assign in_mem = (state_q == S_MEM);

    seq_timeout_cnt #(.LIMIT(8'(MEM_TIMEOUT))) u_timeout (
        .clk_i  (clock),
        .rst_ni (rst_n),
        .clr_i  (!in_mem || bus.dmem_ready),
        .en_i   (in_mem && !bus.dmem_ready),
        .lim_o  (to_lim)
    );

    // halt is only honoured where an instruction boundary is crossed
    assign next_fetch = bus.halt ? S_PAUSE : S_FETCH;
    assign taken      = (bus.Branch & bus.zero) | (bus.nBranch & ~bus.zero);

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEQ;
        retire   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_INIT:  state_d = next_fetch;
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.Jr) begin
                    {pc_we, retire} = 2'b11;
                    pc_sel  = PC_JR;
                    state_d = next_fetch;
                end else if (bus.Jmp || bus.Jal) begin
                    {pc_we, retire} = 2'b11;
                    pc_sel  = PC_JMP;
                    reg_we  = bus.Jal;
                    state_d = next_fetch;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.Branch || bus.nBranch) begin
                    {pc_we, retire} = 2'b11;
                    pc_sel  = taken ? PC_BR : PC_SEQ;
                    state_d = next_fetch;
                end else if (bus.MemWrite || bus.MemtoReg) begin
                    state_d = S_MEM;
                end else if (bus.RegWrite) begin
                    state_d = S_WB;
                end else begin
                    {pc_we, retire} = 2'b11;
                    state_d = next_fetch;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = bus.MemWrite;
                if (bus.dmem_ready) begin
                    if (bus.MemtoReg) begin
                        state_d = S_WB;
                    end else begin
                        {pc_we, retire} = 2'b11;
                        state_d = next_fetch;
                    end
                end else if (to_lim) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                {reg_we, pc_we, retire} = 3'b111;
                state_d = next_fetch;
            end
            S_PAUSE: if (!bus.halt) state_d = S_FETCH;
            S_FAULT: fault = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.ir_we       = ir_we;
    assign bus.dmem_req    = dmem_req;
    assign bus.dmem_we     = dmem_we;
    assign bus.reg_we      = reg_we;
    assign bus.pc_we       = pc_we;
    assign bus.pc_sel      = pc_sel;
    assign bus.retire      = retire;
    assign bus.fault       = fault;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
endmodule
